ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction-fetch initiator for the MIPS core. Owns the fetch PC and drives
//  the byte address into the combinational, word-aligned instruction memory.
//  Captures the returned word into a small prefetch FIFO and hands {instr, pc}
//  to decode over a valid/ready handshake. Accepts branch/jump redirects, and
//  halts with a fault on an out-of-range or misaligned fetch.
// PARAMETERS
//  IMEM_WORDS  32          words present in instruction memory; valid word index 0..IMEM_WORDS-1
//  FIFO_DEPTH  2           prefetch entries (>=1)
//  RESET_PC    32'h0000_0000  fetch PC loaded at reset
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  imem_adr     out  32  byte address to instruction memory (= fetch_pc, combinational)
//  imem_rd      in   32  instruction word returned in the same cycle
//  instr        out  32  instruction at FIFO head
//  instr_pc     out  32  byte address of instr
//  instr_valid  out  1   FIFO head holds a valid entry
//  instr_ready  in   1   decode accepts the head this cycle
//  redirect     in   1   flush and restart fetch at redirect_pc (1-cycle pulse)
//  redirect_pc  in   32  new fetch byte address
//  fault        out  1   fetch halted on a bad address (sticky)
//  fault_pc     out  32  address that caused the fault
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - fetch_pc=RESET_PC; FIFO empty; state=FETCH
//   - instr_valid=0, instr=0, instr_pc=0, fault=0, fault_pc=0
//  States:
//   FETCH: issue fetch_pc every cycle
//   HALT: no pushes; fetch_pc frozen
//  Range check (combinational):
//   - bad = (fetch_pc[31:2] >= IMEM_WORDS) | (fetch_pc[1:0] != 0)
//  Push (FETCH, !bad, !redirect, and (count < FIFO_DEPTH or pop this cycle)):
//   - write {imem_rd, fetch_pc} at tail
//   - fetch_pc <= fetch_pc + 4, mod 2^32
//   - otherwise fetch_pc holds
//  Pop: on instr_valid & instr_ready at the clock edge; head advances.
//  Simultaneous push+pop when full or non-empty: count unchanged; order preserved.
//  Latency: a word pushed at edge N is at the head (instr_valid=1) after edge N.
//   - First instr_valid rises after the first edge following reset release.
//  Throughput: 1 instr/cycle sustained while instr_ready=1.
//  instr, instr_pc hold stable while instr_valid & !instr_ready.
//  Fault (FETCH & bad & !redirect):
//   - no push; fault<=1, fault_pc<=fetch_pc; state<=HALT
//   - entries already in the FIFO still drain to decode
//  Redirect (highest priority, any state):
//   - FIFO flushed at the edge (count=0), so instr_valid=0 the next cycle
//   - any same-cycle pop or push is discarded
//   - fetch_pc<=redirect_pc; fault<=0; state<=FETCH
//   - a misaligned or out-of-range redirect_pc faults in the following cycle via the range check
//  Reset mid-operation: everything returns to reset values immediately, including in-flight FIFO contents.
//  Count register width: $clog2(FIFO_DEPTH+1).
// TESTING
//  T1:
//   - stimulus: imem holds i at word i; instr_ready=1 from reset
//   - required: instr_valid from cycle 1; instr_pc 0,4,8,... with one instr per cycle
//  T2:
//   - stimulus: instr_ready=0 for 5 cycles after the first valid, then 1
//   - required: FIFO fills to 2 and imem_adr stalls at 8; instr_pc=0 held stable
//     while stalled; release yields 0,4,8 with no loss or duplication
//  T3:
//   - stimulus: redirect=1, redirect_pc=0x40, while the FIFO holds 2 entries
//   - required: next cycle instr_valid=0 and imem_adr=0x40; then instr_pc=0x40, 0x44
//  T4:
//   - stimulus: free-run to the end of memory (IMEM_WORDS=32)
//   - required: last delivered instr_pc=0x7C; fault=1, fault_pc=0x80;
//     no further valid instructions
//  T5:
//   - stimulus: redirect_pc=0x0000_0006
//   - required: fault=1, fault_pc=0x6; a later redirect to 0x0 clears fault
//     and fetch resumes
//  T6:
//   - stimulus: reset_n pulsed low mid-stream, asynchronously between edges
//   - required: instr_valid=0 and imem_adr=RESET_PC immediately

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, decode handshake, redirect and fault status.
// The fetch unit is the master; decode/memory/control collectively form the slave side.
interface ifetch_unit_if;
  logic [31:0] imem_adr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_adr,
    input  imem_rd,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_pc,
    output fault,
    output fault_pc
  );

  modport slave (
    input  imem_adr,
    output imem_rd,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_pc,
    input  fault,
    input  fault_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the fetch PC, buffers fetched words in a small
// prefetch FIFO for decode, follows redirects and halts with a sticky fault on bad addresses.
module ifetch_unit #(
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  ifetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {FETCH, HALT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic             valid, bad, push, pop, fault_set;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign valid = (count != '0);
  assign bad   = ({2'b00, fetch_pc[31:2]} >= IMEM_WORDS) || (fetch_pc[1:0] != 2'b00);
  // A redirect discards any same-cycle pop, since the whole FIFO is flushed anyway.
  assign pop   = valid && bus.instr_ready && !bus.redirect;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    fault_set = 1'b0;
    if (bus.redirect) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (bad) begin
            fault_set = 1'b1;
            state_d   = HALT;
          end else if ((count < CNT_W'(FIFO_DEPTH)) || pop) begin
            push = 1'b1;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      fetch_pc     <= RESET_PC;
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      bus.fault    <= 1'b0;
      bus.fault_pc <= '0;
    end else begin
      state_q <= state_d;
      if (bus.redirect) begin
        fetch_pc  <= bus.redirect_pc;
        count     <= '0;
        head      <= '0;
        tail      <= '0;
        bus.fault <= 1'b0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          tail     <= ptr_next(tail);
        end
        if (pop) head <= ptr_next(head);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
        if (fault_set) begin
          bus.fault    <= 1'b1;
          bus.fault_pc <= fetch_pc;
        end
      end
    end
  end

  // Storage needs no reset: outputs are gated by the count, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[tail] <= bus.imem_rd;
      fifo_pc[tail]    <= fetch_pc;
    end
  end

  assign bus.imem_adr    = fetch_pc;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? fifo_instr[head] : 32'h0;
  assign bus.instr_pc    = valid ? fifo_pc[head]    : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized stream
// checked against a transaction-level model (sequential PCs from the last restart point).
module tb_ifetch_unit;

  localparam int IMEM_WORDS = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] imem [IMEM_WORDS];
  int passed = 0;
  int total = 0;

  ifetch_unit_if bus();

  ifetch_unit #(
    .IMEM_WORDS(32),
    .FIFO_DEPTH(2),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Combinational word-aligned instruction memory.
  assign bus.imem_rd = ({2'b00, bus.imem_adr[31:2]} < 32'(IMEM_WORDS)) ?
                       imem[bus.imem_adr[6:2]] : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_imem(input bit seq);
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = seq ? 32'(i) : $urandom;
  endtask

  task automatic do_reset(input logic ready);
    bus.instr_ready = ready;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #2 reset_n = 1'b0;
    #3;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    fill_imem(1'b1);
    reset_n = 1'b0;
    #2;
    total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 32'h0) $display("[TB] FAIL rst_instr: got %h want 0", bus.instr); else passed++;
    total++; if (bus.instr_pc !== 32'h0) $display("[TB] FAIL rst_instr_pc: got %h want 0", bus.instr_pc); else passed++;
    total++; if (bus.fault !== 1'b0) $display("[TB] FAIL rst_fault: got %b want 0", bus.fault); else passed++;
    total++; if (bus.fault_pc !== 32'h0) $display("[TB] FAIL rst_fault_pc: got %h want 0", bus.fault_pc); else passed++;
    total++; if (bus.imem_adr !== 32'h0) $display("[TB] FAIL rst_imem_adr: got %h want 0", bus.imem_adr); else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_stream();
    fill_imem(1'b1);
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      step();
      total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL t1_valid_%0d: got %b want 1", k, bus.instr_valid); else passed++;
      total++; if (bus.instr_pc !== 32'(4 * k)) $display("[TB] FAIL t1_pc_%0d: got %h want %h", k, bus.instr_pc, 32'(4 * k)); else passed++;
      total++; if (bus.instr !== 32'(k)) $display("[TB] FAIL t1_instr_%0d: got %h want %h", k, bus.instr, 32'(k)); else passed++;
    end
  endtask

  task automatic test_stall();
    fill_imem(1'b0);
    do_reset(1'b0);
    step();
    total++; if (bus.instr_valid !== 1'b1) $display("[TB] FAIL t2_first_valid: got %b want 1", bus.instr_valid); else passed++;
    for (int s = 0; s < 5; s++) begin
      step();
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== imem[0])
        $display("[TB] FAIL t2_hold_%0d: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", s, bus.instr_valid, bus.instr_pc, bus.instr, imem[0]);
      else passed++;
      total++; if (bus.imem_adr !== 32'h8) $display("[TB] FAIL t2_adr_%0d: got %h want 8", s, bus.imem_adr); else passed++;
    end
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instr !== imem[k])
        $display("[TB] FAIL t2_drain_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 32'(4 * k), imem[k]);
      else passed++;
      step();
    end
  endtask

  task automatic test_redirect();
    fill_imem(1'b0);
    do_reset(1'b0);
    step();
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) $display("[TB] FAIL t3_pre: got v=%b pc=%h want v=1 pc=0", bus.instr_valid, bus.instr_pc); else passed++;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.instr_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL t3_flush_valid: got %b want 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_adr !== 32'h40) $display("[TB] FAIL t3_adr: got %h want 40", bus.imem_adr); else passed++;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(32'h40 + 4 * k) || bus.instr !== imem[16 + k])
        $display("[TB] FAIL t3_resume_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 32'(32'h40 + 4 * k), imem[16 + k]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] expected_pc = 32'h0;
    logic [31:0] target = 32'h0;
    logic [31:0] held_pc = 32'h0;
    logic [31:0] held_instr = 32'h0;
    bit          prev_stall = 1'b0;
    bit          redirect_last = 1'b0;
    fill_imem(1'b0);
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      step();
      if (redirect_last) begin
        total++; if (bus.instr_valid !== 1'b0 || bus.imem_adr !== target)
          $display("[TB] FAIL rnd_flush_%0d: got v=%b adr=%h want v=0 adr=%h", c, bus.instr_valid, bus.imem_adr, target);
        else passed++;
      end
      if (prev_stall) begin
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== held_pc || bus.instr !== held_instr)
          $display("[TB] FAIL rnd_stable_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, bus.instr_valid, bus.instr_pc, bus.instr, held_pc, held_instr);
        else passed++;
      end
      redirect_last = 1'b0;
      prev_stall    = 1'b0;
      if ($urandom_range(0, 15) == 0 || expected_pc >= 32'h60) begin
        target          = 32'($urandom_range(0, 27)) * 32'd4;
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        bus.instr_ready = 1'($urandom_range(0, 1));
        expected_pc     = target;
        redirect_last   = 1'b1;
      end else begin
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'($urandom_range(0, 1));
        if (bus.instr_valid === 1'b1) begin
          if (bus.instr_ready) begin
            total++; if (bus.instr_pc !== expected_pc || bus.instr !== imem[expected_pc[6:2]])
              $display("[TB] FAIL rnd_deliver_%0d: got pc=%h instr=%h want pc=%h instr=%h", c, bus.instr_pc, bus.instr, expected_pc, imem[expected_pc[6:2]]);
            else passed++;
            expected_pc = expected_pc + 32'd4;
          end else begin
            prev_stall = 1'b1;
            held_pc    = expected_pc;
            held_instr = imem[expected_pc[6:2]];
          end
        end
      end
    end
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_end();
    int delivered = 0;
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    fill_imem(1'b0);
    do_reset(1'b1);
    for (int c = 0; c < 60; c++) begin
      step();
      if (bus.instr_valid === 1'b1) begin
        total++; if (bus.instr_pc !== 32'(4 * delivered))
          $display("[TB] FAIL t4_seq_%0d: got %h want %h", delivered, bus.instr_pc, 32'(4 * delivered));
        else passed++;
        last_pc = bus.instr_pc;
        delivered++;
      end
    end
    total++; if (delivered != IMEM_WORDS) $display("[TB] FAIL t4_count: got %0d want %0d", delivered, IMEM_WORDS); else passed++;
    total++; if (last_pc !== 32'h7C) $display("[TB] FAIL t4_last_pc: got %h want 7c", last_pc); else passed++;
    total++; if (bus.fault !== 1'b1) $display("[TB] FAIL t4_fault: got %b want 1", bus.fault); else passed++;
    total++; if (bus.fault_pc !== 32'h80) $display("[TB] FAIL t4_fault_pc: got %h want 80", bus.fault_pc); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL t4_valid: got %b want 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_adr !== 32'h80) $display("[TB] FAIL t4_frozen_adr: got %h want 80", bus.imem_adr); else passed++;
  endtask

  task automatic test_misaligned();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h6;
    step();
    bus.redirect = 1'b0;
    total++; if (bus.fault !== 1'b0 || bus.imem_adr !== 32'h6) $display("[TB] FAIL t5_redirect: got fault=%b adr=%h want fault=0 adr=6", bus.fault, bus.imem_adr); else passed++;
    step();
    total++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h6) $display("[TB] FAIL t5_fault: got fault=%b fault_pc=%h want fault=1 fault_pc=6", bus.fault, bus.fault_pc); else passed++;
    step();
    total++; if (bus.fault !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_adr !== 32'h6)
      $display("[TB] FAIL t5_sticky: got fault=%b v=%b adr=%h want fault=1 v=0 adr=6", bus.fault, bus.instr_valid, bus.imem_adr);
    else passed++;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    total++; if (bus.fault !== 1'b0) $display("[TB] FAIL t5_clear: got %b want 0", bus.fault); else passed++;
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== imem[0])
      $display("[TB] FAIL t5_resume: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, imem[0]);
    else passed++;
  endtask

  task automatic test_async_reset();
    fill_imem(1'b0);
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) step();
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.instr_valid !== 1'b0) $display("[TB] FAIL t6_valid: got %b want 0", bus.instr_valid); else passed++;
    total++; if (bus.imem_adr !== 32'h0) $display("[TB] FAIL t6_adr: got %h want 0", bus.imem_adr); else passed++;
    total++; if (bus.instr_pc !== 32'h0 || bus.fault !== 1'b0) $display("[TB] FAIL t6_outputs: got pc=%h fault=%b want pc=0 fault=0", bus.instr_pc, bus.fault); else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) $display("[TB] FAIL t6_restart: got v=%b pc=%h want v=1 pc=0", bus.instr_valid, bus.instr_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_random();
    test_end();
    test_misaligned();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
